// File: rtl/flop_pipe_pkg.sv
// Shared types and helpers for the elastic register pipe.
package flop_pipe_pkg;

    // Width of the default stage record (matches the original 8-bit flipflop).
    localparam int DEF_WIDTH = 8;

    // One pipe stage: its valid bit and the word it holds.
    typedef struct packed {
        logic                 v;
        logic [DEF_WIDTH-1:0] d;
    } stage_rec_t;

    // Bits needed to count 0..n inclusive.
    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flop_pipe_if.sv
// Producer/consumer handshake bundle of the elastic pipe.
interface flop_pipe_if import flop_pipe_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int CNT_W = clog2_p1(DEPTH);

    logic [WIDTH-1:0] qin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] qout;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    // Environment side: drives input words, consumer ready and flush.
    modport master (
        output qin, in_valid, out_ready, flush,
        input  in_ready, qout, out_valid, count
    );

    // Pipe side.
    modport slave (
        input  qin, in_valid, out_ready, flush,
        output in_ready, qout, out_valid, count
    );
endinterface

// File: rtl/flop_pipe_stage.sv
// Single elastic register: holds one word plus valid, passes readiness upstream.
module flop_pipe_stage import flop_pipe_pkg::*; #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             v_src_i,
    input  logic [WIDTH-1:0] d_src_i,
    input  logic             rdy_dn_i,
    output logic             rdy_up_o,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Stage can take a word when empty or when its content leaves this cycle.
    always_comb begin
        rdy_up_o = !v_q || rdy_dn_i;
    end

    // Next state: flush clears, otherwise load when ready; data only moves with a valid word.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
            d_d = RESET_VAL;
        end else if (rdy_up_o) begin
            v_d = v_src_i;
            if (v_src_i) begin
                d_d = d_src_i;
            end
        end
    end

    // Stage register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;
endmodule

// File: rtl/flop_pipe.sv
// Chain of DEPTH elastic register stages with valid/ready at both ends,
// synchronous flush and an occupancy counter.
module flop_pipe import flop_pipe_pkg::*; #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic      clk,
    input  logic      reset,
    flop_pipe_if.slave bus
);
    localparam int CNT_W = clog2_p1(DEPTH);

    logic             v_w    [DEPTH];
    logic [WIDTH-1:0] d_w    [DEPTH];
    logic             v_src  [DEPTH];
    logic [WIDTH-1:0] d_src  [DEPTH];
    logic             rdy_up [DEPTH];
    logic             rdy_dn [DEPTH];
    logic [DEPTH-1:0] v_vec;

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign v_src[i] = bus.in_valid;
            assign d_src[i] = bus.qin;
        end else begin : g_body
            assign v_src[i] = v_w[i-1];
            assign d_src[i] = d_w[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign rdy_dn[i] = bus.out_ready;
        end else begin : g_mid
            assign rdy_dn[i] = rdy_up[i+1];
        end

        assign v_vec[i] = v_w[i];

        flop_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush_i  (bus.flush),
            .v_src_i  (v_src[i]),
            .d_src_i  (d_src[i]),
            .rdy_dn_i (rdy_dn[i]),
            .rdy_up_o (rdy_up[i]),
            .v_o      (v_w[i]),
            .d_o      (d_w[i])
        );
    end

    assign in_xfer  = bus.in_valid && rdy_up[0];
    assign out_xfer = v_w[DEPTH-1] && bus.out_ready;

    // Occupancy: flush wins; simultaneous in and out leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = rdy_up[0];
    assign bus.qout      = d_w[DEPTH-1];
    assign bus.out_valid = v_w[DEPTH-1];
    assign bus.count     = count_q;

    // Counter stays within 0..DEPTH and always matches the number of valid stages.
    a_count_ok: assert property (@(posedge clk) disable iff (reset)
        (int'(count_q) <= DEPTH) && (int'(count_q) == $countones(v_vec)));
endmodule
